// File: rtl/mem_pkg.sv
// Shared definitions for the program/data memory slice.
//   mem_state_e  : loader FSM states
//   *_DEFAULT    : default memory size and region-select placement
//   in_region()  : address decode for "this memory owns this byte address"
package mem_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } mem_state_e;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 16384;
  localparam int unsigned REGION_ID_DEFAULT   = 32'h2;
  localparam int unsigned REGION_MSB_DEFAULT  = 19;
  localparam int unsigned REGION_LSB_DEFAULT  = 16;

  // True when the region-select field matches and the word offset inside the
  // region lands inside the physical array.
  function automatic logic in_region(
    input logic [31:0] addr,
    input int unsigned region_id,
    input int unsigned region_msb,
    input int unsigned region_lsb,
    input int unsigned depth_words
  );
    logic [31:0] sel_mask;
    logic [31:0] off_mask;
    logic [31:0] sel;
    logic [31:0] word_off;
    sel_mask = (32'd1 << (region_msb - region_lsb + 1)) - 32'd1;
    off_mask = (32'd1 << region_lsb) - 32'd1;
    sel      = (addr >> region_lsb) & sel_mask;
    word_off = (addr & off_mask) >> 2;
    return (sel == region_id) && (word_off < depth_words);
  endfunction

endpackage

// File: rtl/mem_req_pipe.sv
// Request tracking pipe: carries valid and fault alongside the RAM read
// pipeline so the response appears exactly LATENCY cycles after the request.
//   clk_in, rst_in : clock, synchronous active-high reset (drops in-flight entries)
//   req_in         : request accepted this cycle
//   fault_in       : accepted request is faulting
//   valid_out      : response valid
//   fault_out      : response is a fault (only meaningful with valid_out)
module mem_req_pipe #(
  parameter int LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic req_in,
  input  logic fault_in,
  output logic valid_out,
  output logic fault_out
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] fault_q, fault_d;

  always_comb begin
    valid_d = LATENCY'({valid_q, req_in});
    fault_d = LATENCY'({fault_q, req_in & fault_in});
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      fault_q <= '0;
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign valid_out = valid_q[LATENCY-1];
  assign fault_out = fault_q[LATENCY-1];

endmodule

// File: rtl/xilinx_true_dual_port_read_first_byte_write_2_clock_ram.sv
// Behavioural model of the true dual-port, read-first, byte-write block RAM.
//   addra/addrb, dina/dinb, wea/web, ena/enb : per-port access
//   clka/clkb                                : port clocks
//   rsta/rstb, regcea/regceb                 : output-register reset / enable
//   douta/doutb                              : read data (old word on write)
// Both ports write the array from the port-A clock process so the array has a
// single driver; this model is only valid with clka and clkb tied together.
module xilinx_true_dual_port_read_first_byte_write_2_clock_ram #(
  parameter int    NB_COL          = 4,
  parameter int    COL_WIDTH       = 8,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0]  addra,
  input  logic [$clog2(RAM_DEPTH)-1:0]  addrb,
  input  logic [NB_COL*COL_WIDTH-1:0]   dina,
  input  logic [NB_COL*COL_WIDTH-1:0]   dinb,
  input  logic                          clka,
  input  logic                          clkb,
  input  logic [NB_COL-1:0]             wea,
  input  logic [NB_COL-1:0]             web,
  input  logic                          ena,
  input  logic                          enb,
  input  logic                          rsta,
  input  logic                          rstb,
  input  logic                          regcea,
  input  logic                          regceb,
  output logic [NB_COL*COL_WIDTH-1:0]   douta,
  output logic [NB_COL*COL_WIDTH-1:0]   doutb
);

  localparam int W = NB_COL * COL_WIDTH;

  logic [W-1:0] ram [RAM_DEPTH];
  logic [W-1:0] ram_data_a;
  logic [W-1:0] ram_data_b;

  // Non-blocking writes keep both reads read-first.
  always_ff @(posedge clka) begin
    if (ena) begin
      ram_data_a <= ram[addra];
      for (int i = 0; i < NB_COL; i++) begin
        if (wea[i]) ram[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
      end
    end
    if (enb) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (web[i]) ram[addrb][i*COL_WIDTH +: COL_WIDTH] <= dinb[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  always_ff @(posedge clkb) begin
    if (enb) ram_data_b <= ram[addrb];
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
    assign douta = ram_data_a;
    assign doutb = ram_data_b;
  end else begin : g_out_reg
    logic [W-1:0] douta_q;
    logic [W-1:0] doutb_q;
    always_ff @(posedge clka) begin
      if (rsta)        douta_q <= '0;
      else if (regcea) douta_q <= ram_data_a;
    end
    always_ff @(posedge clkb) begin
      if (rstb)        doutb_q <= '0;
      else if (regceb) doutb_q <= ram_data_b;
    end
    assign douta = douta_q;
    assign doutb = doutb_q;
  end

endmodule

// File: rtl/program_mem.sv
// Program/data memory: read-only fetch port, byte-writable data port and a
// streaming loader that owns port A while the core is stalled.
//   clk_in, rst_in                 : clock, synchronous active-high reset
//   imem_req/addr -> valid/data/fault : fetch port (port A in RUN)
//   dmem_req/addr/data/we -> valid/data/fault : data port (port B)
//   load_en/valid/addr/data -> load_ready : loader (port A in LOAD)
//   stall_out                      : core must hold; requests ignored while high
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | imem on port A, dmem on port B, requests accepted
// LOAD  | loader owns port A, stall + ready high, requests ignored
// DRAIN | stall held READ_LATENCY cycles while the RAM pipeline empties
module program_mem
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = DEPTH_WORDS_DEFAULT,
  parameter int unsigned REGION_ID    = REGION_ID_DEFAULT,
  parameter int unsigned REGION_MSB   = REGION_MSB_DEFAULT,
  parameter int unsigned REGION_LSB   = REGION_LSB_DEFAULT,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        imem_req_in,
  input  logic [31:0] imem_addr_in,
  output logic        imem_valid_out,
  output logic [31:0] imem_data_out,
  output logic        imem_fault_out,
  input  logic        dmem_req_in,
  input  logic [31:0] dmem_addr_in,
  input  logic [31:0] dmem_data_in,
  input  logic [3:0]  dmem_we_in,
  output logic        dmem_valid_out,
  output logic [31:0] dmem_data_out,
  output logic        dmem_fault_out,
  input  logic        load_en_in,
  input  logic        load_valid_in,
  input  logic [31:0] load_addr_in,
  input  logic [31:0] load_data_in,
  output logic        load_ready_out,
  output logic        stall_out
);

  localparam int    IDX_W    = $clog2(DEPTH_WORDS);
  localparam string RAM_PERF = (READ_LATENCY == 1) ? "LOW_LATENCY" : "HIGH_PERFORMANCE";

  mem_state_e state_q, state_d;
  logic       stall_q, stall_d;
  logic       load_ready_q, load_ready_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;

  logic             run_mode;
  logic             imem_acc, imem_fault;
  logic             dmem_acc, dmem_fault;
  logic             load_wr;
  logic [IDX_W-1:0] addra, addrb;
  logic [3:0]       wea, web;
  logic [31:0]      douta, doutb;

  assign run_mode   = (state_q == RUN);
  assign imem_acc   = imem_req_in & run_mode;
  assign imem_fault = !in_region(imem_addr_in, REGION_ID, REGION_MSB, REGION_LSB, DEPTH_WORDS)
                      || (imem_addr_in[1:0] != 2'b00);
  assign dmem_acc   = dmem_req_in & run_mode;
  assign dmem_fault = !in_region(dmem_addr_in, REGION_ID, REGION_MSB, REGION_LSB, DEPTH_WORDS);
  // Out-of-region load words are dropped without any indication.
  assign load_wr    = load_valid_in & load_ready_q
                      & in_region(load_addr_in, REGION_ID, REGION_MSB, REGION_LSB, DEPTH_WORDS);

  assign addra = (state_q == LOAD) ? load_addr_in[IDX_W+1:2] : imem_addr_in[IDX_W+1:2];
  assign wea   = load_wr ? 4'hF : 4'h0;
  assign addrb = dmem_addr_in[IDX_W+1:2];
  assign web   = (dmem_acc & ~dmem_fault) ? dmem_we_in : 4'h0;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      RUN:   if (load_en_in) state_d = LOAD;
      LOAD:  if (!load_en_in) begin
               state_d     = DRAIN;
               drain_cnt_d = 2'(READ_LATENCY - 1);
             end
      DRAIN: if (drain_cnt_q == 2'd0) state_d = RUN;
             else drain_cnt_d = drain_cnt_q - 2'd1;
      default: state_d = RUN;
    endcase
    // Outputs follow the next state so stall rises together with the transition.
    stall_d      = (state_d != RUN);
    load_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= RUN;
      stall_q      <= 1'b0;
      load_ready_q <= 1'b0;
      drain_cnt_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      load_ready_q <= load_ready_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign stall_out      = stall_q;
  assign load_ready_out = load_ready_q;

  mem_req_pipe #(.LATENCY(READ_LATENCY)) u_imem_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_in    (imem_acc),
    .fault_in  (imem_fault),
    .valid_out (imem_valid_out),
    .fault_out (imem_fault_out)
  );

  mem_req_pipe #(.LATENCY(READ_LATENCY)) u_dmem_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_in    (dmem_acc),
    .fault_in  (dmem_fault),
    .valid_out (dmem_valid_out),
    .fault_out (dmem_fault_out)
  );

  xilinx_true_dual_port_read_first_byte_write_2_clock_ram #(
    .NB_COL          (4),
    .COL_WIDTH       (8),
    .RAM_DEPTH       (DEPTH_WORDS),
    .RAM_PERFORMANCE (RAM_PERF)
  ) u_ram (
    .addra  (addra),
    .addrb  (addrb),
    .dina   (load_data_in),
    .dinb   (dmem_data_in),
    .clka   (clk_in),
    .clkb   (clk_in),
    .wea    (wea),
    .web    (web),
    .ena    (1'b1),
    .enb    (1'b1),
    .rsta   (rst_in),
    .rstb   (rst_in),
    .regcea (1'b1),
    .regceb (1'b1),
    .douta  (douta),
    .doutb  (doutb)
  );

  // RAM output is live every cycle; only hand it out on a good response.
  assign imem_data_out = (imem_valid_out && !imem_fault_out) ? douta : 32'h0;
  assign dmem_data_out = (dmem_valid_out && !dmem_fault_out) ? doutb : 32'h0;

endmodule

// File: tb/tb_program_mem.sv
module tb_program_mem;

  localparam int LAT = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        imem_req_in, imem_valid_out, imem_fault_out;
  logic [31:0] imem_addr_in, imem_data_out;
  logic        dmem_req_in, dmem_valid_out, dmem_fault_out;
  logic [31:0] dmem_addr_in, dmem_data_in, dmem_data_out;
  logic [3:0]  dmem_we_in;
  logic        load_en_in, load_valid_in, load_ready_out, stall_out;
  logic [31:0] load_addr_in, load_data_in;

  always #5 clk_in = ~clk_in;

  program_mem dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .imem_req_in    (imem_req_in),
    .imem_addr_in   (imem_addr_in),
    .imem_valid_out (imem_valid_out),
    .imem_data_out  (imem_data_out),
    .imem_fault_out (imem_fault_out),
    .dmem_req_in    (dmem_req_in),
    .dmem_addr_in   (dmem_addr_in),
    .dmem_data_in   (dmem_data_in),
    .dmem_we_in     (dmem_we_in),
    .dmem_valid_out (dmem_valid_out),
    .dmem_data_out  (dmem_data_out),
    .dmem_fault_out (dmem_fault_out),
    .load_en_in     (load_en_in),
    .load_valid_in  (load_valid_in),
    .load_addr_in   (load_addr_in),
    .load_data_in   (load_data_in),
    .load_ready_out (load_ready_out),
    .stall_out      (stall_out)
  );

  typedef struct {
    bit          v;
    bit          f;
    bit          k;   // data known to the model
    logic [31:0] d;
  } resp_t;

  int checks = 0;
  int errors = 0;
  int e      = 0;     // posedges seen at the current sampling point

  // stimulus for the next step
  bit          s_ireq, s_dreq, s_len, s_lval;
  logic [31:0] s_iaddr, s_daddr, s_ddata, s_laddr, s_ldata;
  logic [3:0]  s_dwe;

  // reference model
  localparam int M_RUN = 0, M_LOAD = 1, M_DRAIN = 2;
  int          m_mode  = M_RUN;
  int          m_drain = 0;
  logic [31:0] mem [int];
  resp_t       exp_i [int];
  resp_t       exp_d [int];
  bit          exp_stall [int];
  bit          exp_ready [int];

  function automatic bit inr(input logic [31:0] a);
    return (((a >> 16) & 32'hF) == 32'h2) && (((a & 32'hFFFF) >> 2) < 32'd16384);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FFF);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] we);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (we[b]) m = m | (32'hFF << (8 * b));
    return (old_w & ~m) | (new_w & m);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int          sel;
    sel = $urandom_range(0, 7);
    a   = 32'h0002_0000 + 32'($urandom_range(0, 15)) * 4;
    if (sel == 0) a = a ^ 32'h0001_0000;
    if (sel == 1) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h want %h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic check_outputs();
    resp_t ri, rd;
    bit    st, rdy;
    ri  = exp_i.exists(e) ? exp_i[e] : '{v: 1'b0, f: 1'b0, k: 1'b1, d: 32'h0};
    rd  = exp_d.exists(e) ? exp_d[e] : '{v: 1'b0, f: 1'b0, k: 1'b1, d: 32'h0};
    st  = exp_stall.exists(e) ? exp_stall[e] : 1'b0;
    rdy = exp_ready.exists(e) ? exp_ready[e] : 1'b0;
    chk("imem_valid", 32'(imem_valid_out), 32'(ri.v));
    chk("imem_fault", 32'(imem_fault_out), 32'(ri.f));
    if (ri.k) chk("imem_data", imem_data_out, ri.d);
    chk("dmem_valid", 32'(dmem_valid_out), 32'(rd.v));
    chk("dmem_fault", 32'(dmem_fault_out), 32'(rd.f));
    if (rd.k) chk("dmem_data", dmem_data_out, rd.d);
    chk("stall", 32'(stall_out), 32'(st));
    chk("load_ready", 32'(load_ready_out), 32'(rdy));
  endtask

  task automatic step(input bit rst_v);
    resp_t r;
    int    idx;
    check_outputs();
    rst_in        = rst_v;
    imem_req_in   = s_ireq;
    imem_addr_in  = s_iaddr;
    dmem_req_in   = s_dreq;
    dmem_addr_in  = s_daddr;
    dmem_data_in  = s_ddata;
    dmem_we_in    = s_dwe;
    load_en_in    = s_len;
    load_valid_in = s_lval;
    load_addr_in  = s_laddr;
    load_data_in  = s_ldata;
    if (rst_v) begin
      m_mode = M_RUN;
      for (int k = e + 1; k <= e + LAT; k++) begin
        if (exp_i.exists(k)) exp_i.delete(k);
        if (exp_d.exists(k)) exp_d.delete(k);
      end
    end else begin
      if (m_mode == M_RUN) begin
        if (s_ireq) begin
          idx = widx(s_iaddr);
          r.v = 1'b1;
          r.f = !inr(s_iaddr) || (s_iaddr[1:0] != 2'b00);
          r.k = r.f ? 1'b1 : mem.exists(idx);
          r.d = (!r.f && r.k) ? mem[idx] : 32'h0;
          exp_i[e + LAT] = r;
        end
        if (s_dreq) begin
          idx = widx(s_daddr);
          r.v = 1'b1;
          r.f = !inr(s_daddr);
          r.k = r.f ? 1'b1 : mem.exists(idx);
          r.d = (!r.f && r.k) ? mem[idx] : 32'h0;
          exp_d[e + LAT] = r;
          if (!r.f && s_dwe != 4'h0) begin
            if (mem.exists(idx))      mem[idx] = merge(mem[idx], s_ddata, s_dwe);
            else if (s_dwe == 4'hF)   mem[idx] = s_ddata;
          end
        end
      end
      if (m_mode == M_LOAD && s_lval && inr(s_laddr)) mem[widx(s_laddr)] = s_ldata;
      case (m_mode)
        M_RUN:  if (s_len) m_mode = M_LOAD;
        M_LOAD: if (!s_len) begin m_mode = M_DRAIN; m_drain = LAT; end
        default: begin
          m_drain--;
          if (m_drain == 0) m_mode = M_RUN;
        end
      endcase
      exp_stall[e + 1] = (m_mode != M_RUN);
      exp_ready[e + 1] = (m_mode == M_LOAD);
    end
    @(negedge clk_in);
    e++;
  endtask

  task automatic idle();
    s_ireq = 0; s_dreq = 0; s_len = 0; s_lval = 0;
    s_iaddr = 32'h0; s_daddr = 32'h0; s_ddata = 32'h0; s_dwe = 4'h0;
    s_laddr = 32'h0; s_ldata = 32'h0;
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    imem_req_in = 0; imem_addr_in = 0; dmem_req_in = 0; dmem_addr_in = 0;
    dmem_data_in = 0; dmem_we_in = 0; load_en_in = 0; load_valid_in = 0;
    load_addr_in = 0; load_data_in = 0;
    @(negedge clk_in);
    e = 1;
    step(1); step(1);
    step(0);

    // load phase: stall next cycle, three accepted words, one dropped
    s_len = 1; step(0);
    s_lval = 1; s_laddr = 32'h0002_0010; s_ldata = 32'hDEAD_BEEF; step(0);
    s_laddr = 32'h0003_0010; s_ldata = 32'h5555_5555; step(0);
    s_laddr = 32'h0002_0004; s_ldata = 32'hAAAA_AAAA; step(0);
    s_laddr = 32'h0002_0008; s_ldata = 32'h0000_0000;
    s_ireq = 1; s_iaddr = 32'h0002_0010; s_dreq = 1; s_daddr = 32'h0002_0004; step(0);
    idle(); s_ireq = 1; s_iaddr = 32'h0002_0004; step(0);   // load_en low, still LOAD
    step(0); step(0);                                       // drain: requests ignored
    idle(); step(0);

    // fetch of loaded word
    s_ireq = 1; s_iaddr = 32'h0002_0010; step(0);
    idle(); step(0); step(0);

    // byte write then read back
    s_dreq = 1; s_daddr = 32'h0002_0004; s_ddata = 32'h1234_5678; s_dwe = 4'b0011; step(0);
    s_ddata = 32'h0; s_dwe = 4'h0; step(0);
    idle(); step(0); step(0);

    // faults: out of region, misaligned, faulting write aliasing word 1
    s_dreq = 1; s_daddr = 32'h0003_0000; s_ireq = 1; s_iaddr = 32'h0002_0002; step(0);
    s_ireq = 0; s_daddr = 32'h0003_0004; s_ddata = 32'hFFFF_FFFF; s_dwe = 4'hF; step(0);
    s_daddr = 32'h0002_0004; s_dwe = 4'h0; step(0);
    idle(); step(0); step(0);

    // same-cycle dmem write and imem read of one word
    s_dreq = 1; s_daddr = 32'h0002_0008; s_ddata = 32'h1; s_dwe = 4'hF;
    s_ireq = 1; s_iaddr = 32'h0002_0008; step(0);
    s_dreq = 0; s_dwe = 4'h0; step(0);
    idle(); step(0); step(0);

    // reset while in LOAD with a fetch in flight
    s_len = 1; s_ireq = 1; s_iaddr = 32'h0002_0010; step(0);
    idle(); s_len = 1; step(1);
    idle(); step(0);
    s_ireq = 1; s_iaddr = 32'h0002_0010; step(0);
    idle(); step(0); step(0);

    // preload a 16-word window, then random traffic
    s_len = 1; step(0);
    for (int i = 0; i < 16; i++) begin
      s_lval = 1; s_laddr = 32'h0002_0000 + 32'(i) * 4; s_ldata = $urandom; step(0);
    end
    idle(); step(0); step(0); step(0); step(0);

    for (int i = 0; i < 400; i++) begin
      s_len   = ((i % 80) >= 60) && ((i % 80) < 70);
      s_lval  = 1'($urandom_range(0, 1));
      s_laddr = rand_addr();
      s_ldata = $urandom;
      s_ireq  = 1'($urandom_range(0, 1));
      s_iaddr = rand_addr();
      s_dreq  = 1'($urandom_range(0, 1));
      s_daddr = rand_addr();
      s_ddata = $urandom;
      s_dwe   = 4'($urandom_range(0, 15));
      step(0);
    end
    idle();
    for (int i = 0; i < 5; i++) step(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
